// File: rtl/fadd_arb_pkg.sv
// Shared constants for the FP-adder arbiter: data width and FSM state encoding.
package fadd_arb_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the lowest request above ptr wins, otherwise
// the lowest request overall. Returns a one-hot grant, its index and an any flag.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0] upper;
    logic [N-1:0] pool;

    always_comb begin
        // Keep only requests strictly above ptr; wrap to the full vector if none.
        upper = req & ~((N'(2) << ptr) - N'(1));
        pool  = (upper != '0) ? upper : req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pool[i]) idx = IDX_W'(i);
        end
        any = |req;
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one FP adder among NREQ requesters, one operation in flight at a time.
// Define FADD_ARB_TIMEOUT_EN to abort a stalled adder after TIMEOUT WAIT cycles.
module fadd_arbiter
    import fadd_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_stb,
    input  logic [NREQ*WORD_W-1:0] req_a,
    input  logic [NREQ*WORD_W-1:0] req_b,
    output logic [NREQ-1:0]        req_gnt,
    output logic [NREQ-1:0]        req_done,
    input  logic [NREQ-1:0]        req_ack,
    output logic [WORD_W-1:0]      req_result,
    output logic                   req_err,
    output logic                   add_load,
    output logic [WORD_W-1:0]      add_a,
    output logic [WORD_W-1:0]      add_b,
    input  logic                   add_ready,
    input  logic [WORD_W-1:0]      add_result,
    output logic                   add_ack,
    output logic [1:0]             dbg_state
);

    localparam int IDX_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("fadd_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic [WORD_W-1:0] result_q, result_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              ack_q, ack_d;

    logic [NREQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

`ifdef FADD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    rr_pick #(.N(NREQ), .IDX_W(IDX_W)) u_pick (
        .req (req_stb),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        gnt_d    = '0;
        done_d   = done_q;
        ack_d    = ack_q;
`ifdef FADD_ARB_TIMEOUT_EN
        err_d    = err_q;
        cnt_d    = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    win_d   = pick_idx;
                    ptr_d   = pick_idx;
                    a_d     = req_a[int'(pick_idx) * WORD_W +: WORD_W];
                    b_d     = req_b[int'(pick_idx) * WORD_W +: WORD_W];
                    gnt_d   = pick_gnt;
                    ack_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (add_ready) begin
                    result_d = add_result;
                    ack_d    = 1'b1;
                    done_d   = NREQ'(1) << win_q;
                    state_d  = ST_DELIVER;
                end
`ifdef FADD_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Stalled adder: deliver a zero result flagged as an error.
                    result_d = '0;
                    err_d    = 1'b1;
                    ack_d    = 1'b1;
                    done_d   = NREQ'(1) << win_q;
                    state_d  = ST_DELIVER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_DELIVER: begin
                if (req_ack[win_q]) begin
                    done_d  = '0;
`ifdef FADD_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= IDX_W'(NREQ - 1);
            win_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            ack_q    <= 1'b0;
`ifdef FADD_ARB_TIMEOUT_EN
            err_q    <= 1'b0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            ack_q    <= ack_d;
`ifdef FADD_ARB_TIMEOUT_EN
            err_q    <= err_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign req_gnt    = gnt_q;
    assign req_done   = done_q;
    assign req_result = result_q;
    assign add_load   = (state_q == ST_ISSUE);
    assign add_a      = a_q;
    assign add_b      = b_q;
    assign add_ack    = ack_q;
    assign dbg_state  = state_q;
`ifdef FADD_ARB_TIMEOUT_EN
    assign req_err    = err_q;
`else
    assign req_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fadd_arbiter.sv
// Bench for fadd_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the arbitration rules.
module tb_fadd_arbiter;
    import fadd_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int W       = 32;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_stb;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_gnt;
    logic [NREQ-1:0]   req_done;
    logic [NREQ-1:0]   req_ack;
    logic [W-1:0]      req_result;
    logic              req_err;
    logic              add_load;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_ready;
    logic [W-1:0]      add_result;
    logic              add_ack;
    logic [1:0]        dbg_state;

    fadd_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_stb    (req_stb),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_gnt    (req_gnt),
        .req_done   (req_done),
        .req_ack    (req_ack),
        .req_result (req_result),
        .req_err    (req_err),
        .add_load   (add_load),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_ready  (add_ready),
        .add_result (add_result),
        .add_ack    (add_ack),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        $display("FAIL %s: no DUT response within cycle budget (t=%0t)", name, $time);
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    // One transaction at a time: who owns the adder, and how far it has got.
    int              m_stage;   // 0 free, 1 operands issued, 2 awaiting adder, 3 result out
    int              m_owner;
    int              m_ptr;
    int              m_waited;
    logic [NREQ-1:0] e_gnt, e_done;
    logic            e_err, e_load, e_ack;
    logic [W-1:0]    e_result, e_a, e_b;

    function automatic int rr_winner(input logic [NREQ-1:0] stb, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (last + k) % NREQ;
            if (stb[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_stage  = 0;
        m_owner  = 0;
        m_ptr    = NREQ - 1;
        m_waited = 0;
        e_gnt    = '0;
        e_done   = '0;
        e_err    = 1'b0;
        e_load   = 1'b0;
        e_ack    = 1'b0;
        e_result = '0;
        e_a      = '0;
        e_b      = '0;
    endtask

    task automatic model_step();
        int w;
        e_gnt  = '0;
        e_load = 1'b0;
        case (m_stage)
            0: if (req_stb != '0) begin
                w        = rr_winner(req_stb, m_ptr);
                m_owner  = w;
                m_ptr    = w;
                e_gnt[w] = 1'b1;
                e_load   = 1'b1;
                e_a      = req_a[w*W +: W];
                e_b      = req_b[w*W +: W];
                e_ack    = 1'b0;
                m_stage  = 1;
            end
            1: begin
                m_waited = 0;
                m_stage  = 2;
            end
            2: if (add_ready) begin
                e_result         = add_result;
                e_done           = '0;
                e_done[m_owner]  = 1'b1;
                e_ack            = 1'b1;
                m_stage          = 3;
            end else begin
`ifdef FADD_ARB_TIMEOUT_EN
                m_waited++;
                if (m_waited == TIMEOUT) begin
                    e_result        = '0;
                    e_err           = 1'b1;
                    e_done          = '0;
                    e_done[m_owner] = 1'b1;
                    e_ack           = 1'b1;
                    m_stage         = 3;
                end
`endif
            end
            default: if (req_ack[m_owner]) begin
                e_done  = '0;
                e_err   = 1'b0;
                m_stage = 0;
            end
        endcase
    endtask

    always @(posedge clk) if (reset) model_step();

    // ---------------- compare process and monitors ----------------
    int              load_cnt = 0;
    int              gnt_cnt = 0;
    int              done_rise = 0;
    int              done_cycles = 0;
    logic [NREQ-1:0] done_prev = '0;
    logic            load_seen = 1'b0;
    logic [W-1:0]    load_a, load_b;
    bit              gnt_log_en = 1'b0;
    logic [W-1:0]    exp_q[$];

    always @(negedge clk) begin
        if (!reset) model_reset();
        check("gnt",     W'(req_gnt),  W'(e_gnt));
        check("done",    W'(req_done), W'(e_done));
        check("err",     W'(req_err),  W'(e_err));
        check("result",  req_result,   e_result);
        check("load",    W'(add_load), W'(e_load));
        check("add_a",   add_a,        e_a);
        check("add_b",   add_b,        e_b);
        check("add_ack", W'(add_ack),  W'(e_ack));
        if (add_load) begin
            load_cnt++;
            load_seen = 1'b1;
            load_a    = add_a;
            load_b    = add_b;
        end
        if (req_gnt != '0) begin
            gnt_cnt++;
            if (gnt_log_en) begin
                if (exp_q.size() == 0) fail_bound("grant_order_extra");
                else check("grant_order", W'(onehot_idx(req_gnt)), exp_q.pop_front());
            end
        end
        if (req_done != '0) done_cycles++;
        if (req_done != '0 && done_prev == '0) done_rise++;
        done_prev = req_done;
    end

    // ---------------- adder model ----------------
    bit   stall = 1'b0;
    bit   spur_en = 1'b0;
    bit   add_busy = 1'b0;
    int   add_lat = 0;
    logic [W-1:0] pend_a, pend_b;

    function automatic logic [W-1:0] add_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    initial begin
        add_ready  = 1'b0;
        add_result = '0;
        forever begin
            @(posedge clk);
            #1;
            add_ready = 1'b0;
            if (!reset) begin
                add_busy  = 1'b0;
                load_seen = 1'b0;
            end else begin
                if (load_seen) begin
                    load_seen = 1'b0;
                    add_busy  = 1'b1;
                    add_lat   = $urandom_range(1, 3);
                    pend_a    = load_a;
                    pend_b    = load_b;
                end
                if (add_busy) begin
                    if (add_lat > 1) add_lat--;
                    else if (!stall) begin
                        add_ready  = 1'b1;
                        add_result = add_fn(pend_a, pend_b);
                        add_busy   = 1'b0;
                    end
                end else if (spur_en && $urandom_range(0, 5) == 0) begin
                    add_ready  = 1'b1;
                    add_result = $urandom;
                end
            end
        end
    end

    // ---------------- result consumer ----------------
    int ack_delay = 0;    // negative selects a random delay per result
    bit noise_en = 1'b0;
    bit ack_armed = 1'b0;
    int ack_wait = 0;

    initial begin
        req_ack = '0;
        forever begin
            @(posedge clk);
            #1;
            req_ack = '0;
            if (!reset) ack_armed = 1'b0;
            else if (req_done != '0) begin
                if (!ack_armed) begin
                    ack_armed = 1'b1;
                    ack_wait  = (ack_delay < 0) ? $urandom_range(0, 4) : ack_delay;
                end
                if (ack_wait == 0) begin
                    req_ack   = req_done;
                    ack_armed = 1'b0;
                end else ack_wait--;
            end
            if (noise_en) req_ack = req_ack | (NREQ'($urandom) & ~req_done);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_gnt(output int idx, input string name, input int limit);
        idx = -1;
        for (int n = 0; n < limit; n++) begin
            tick(1);
            if (req_gnt != '0) begin
                idx = onehot_idx(req_gnt);
                return;
            end
        end
        fail_bound(name);
    endtask

    task automatic wait_done(output int cycles, input string name, input int limit);
        cycles = 0;
        for (int n = 1; n <= limit; n++) begin
            tick(1);
            if (req_done != '0) begin
                cycles = n;
                return;
            end
        end
        fail_bound(name);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        tick(n);
        reset = 1'b1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int idx;
        int cyc;
        int snap_g, snap_d, snap_c, snap_l;

        reset   = 1'b0;
        req_stb = '0;
        req_a   = '0;
        req_b   = '0;
        model_reset();

        // reset values
        tick(2);
        @(negedge clk);
        check("rst_gnt",    W'(req_gnt),  '0);
        check("rst_result", req_result,   '0);
        check("rst_add_a",  add_a,        '0);
        check("rst_ack",    W'(add_ack),  '0);
        tick(1);
        reset = 1'b1;

        // single request 1.0 + 2.0
        set_ops(0, 32'h3F80_0000, 32'h4000_0000);
        snap_l  = load_cnt;
        req_stb = 4'b0001;
        wait_gnt(idx, "t1_gnt", 10);
        check("t1_gnt_idx", W'(idx), 0);
        req_stb = '0;
        wait_done(cyc, "t1_done", 20);
        check("t1_done_vec", W'(req_done), W'(4'b0001));
        check("t1_result",   req_result,   32'h4040_0000);
        tick(4);
        check("t1_loads", W'(load_cnt - snap_l), 1);

        // all four held, immediate ack: rotation from requester 0
        apply_reset(2);
        for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom);
        exp_q      = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        gnt_log_en = 1'b1;
        req_stb    = 4'b1111;
        for (int k = 0; k < 5; k++) wait_gnt(idx, "t2_gnt", 20);
        req_stb = '0;
        tick(20);
        gnt_log_en = 1'b0;
        check("t2_order_left", W'(exp_q.size()), 0);

        // after requester 0 served, 0101 goes to requester 2
        req_stb = 4'b0101;
        wait_gnt(idx, "t3_gnt", 10);
        check("t3_gnt_idx", W'(idx), 2);
        req_stb = '0;
        tick(20);

        // slow consumer with adder and ack noise in the background
        ack_delay = 10;
        spur_en   = 1'b1;
        noise_en  = 1'b1;
        snap_g    = gnt_cnt;
        snap_d    = done_rise;
        snap_c    = done_cycles;
        set_ops(1, $urandom, $urandom);
        req_stb = 4'b0010;
        wait_gnt(idx, "t4_gnt", 10);
        check("t4_gnt_idx", W'(idx), 1);
        req_stb = '0;
        tick(40);
        check("t4_grants",   W'(gnt_cnt - snap_g),     1);
        check("t4_dones",    W'(done_rise - snap_d),   1);
        check("t4_done_len", W'(done_cycles - snap_c), 11);

        // stalled adder
        ack_delay = 0;
        spur_en   = 1'b0;
        noise_en  = 1'b0;
        stall     = 1'b1;
        set_ops(3, $urandom, $urandom);
        req_stb = 4'b1000;
        wait_gnt(idx, "t5_gnt", 10);
        check("t5_gnt_idx", W'(idx), 3);
        req_stb = '0;
`ifdef FADD_ARB_TIMEOUT_EN
        wait_done(cyc, "t5_timeout", TIMEOUT + 20);
        check("t5_latency", W'(cyc), W'(TIMEOUT + 1));
        check("t5_err",     W'(req_err),  1);
        check("t5_result",  req_result,   '0);
        check("t5_done",    W'(req_done), W'(4'b1000));
        tick(3);
        req_stb = 4'b0001;
        wait_gnt(idx, "t5_regnt", 10);
        req_stb = '0;
        tick(5);
`else
        tick(100);
        check("t5_no_done", W'(req_done),  '0);
        check("t5_in_wait", W'(dbg_state), W'(ST_WAIT));
`endif

        // reset while waiting on the adder
        reset = 1'b0;
        @(negedge clk);
        check("t6_gnt",    W'(req_gnt),  '0);
        check("t6_done",   W'(req_done), '0);
        check("t6_result", req_result,   '0);
        check("t6_load",   W'(add_load), '0);
        check("t6_add_b",  add_b,        '0);
        check("t6_ack",    W'(add_ack),  '0);
        tick(2);
        stall   = 1'b0;
        reset   = 1'b1;
        req_stb = 4'b1111;
        wait_gnt(idx, "t6_gnt_after", 10);
        check("t6_first_winner", W'(idx), 0);
        req_stb = '0;
        tick(20);

        // random traffic
        ack_delay = -1;
        spur_en   = 1'b1;
        noise_en  = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_stb[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_stb[i] = 1'b1;
                        set_ops(i, $urandom, $urandom);
                    end
                end else if (req_gnt[i]) begin
                    if ($urandom_range(0, 1) == 0) req_stb[i] = 1'b0;
                    else set_ops(i, $urandom, $urandom);
                end else if ($urandom_range(0, 31) == 0) begin
                    req_stb[i] = 1'b0;
                end
            end
            tick(1);
        end
        req_stb = '0;
        tick(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
